window_buffer_9x9_ctrl: RTL and testbench
=========================================

WINDOW_BUFFER_9X9_CTRL -- requirements
Module: window_buffer_9x9_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 640: pixels per image row; legal range 9..1023.
REQ-002 SHALL have parameter ROWS, default 480: rows per frame; legal range 9..1023.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start_i  input  1  frame start pulse; sampled only in IDLE.
REQ-006 SHALL have port in_valid_i  input  1  one 9-pixel column (S1..S9) presented to the datapath this cycle.
REQ-007 SHALL have port count_en_o  output  1  column-accept strobe to the datapath.
REQ-008 SHALL have port win_valid_o  output  1  datapath 9x9 window outputs hold a complete window this cycle.
REQ-009 SHALL have port win_col_o  output  10  left column index of the current window.
REQ-010 SHALL have port win_row_o  output  10  band index (top row) of the current window.
REQ-011 SHALL have port busy_o  output  1  high in every state except IDLE.
REQ-012 SHALL have port done_o  output  1  one-cycle end-of-frame pulse.
REQ-013 SHALL have port err_o  output  1  sticky mid-row gap error flag.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT_ROW, ROW, FLUSH, ERR.
REQ-015 SHALL keep col_cnt (10b, 0..COLS-1) and band_cnt (10b, 0..ROWS-9).
REQ-016 IDLE: start_i=1 -> WAIT_ROW, col_cnt=0, band_cnt=0, err_o cleared; start_i ignored in all other states.
REQ-017 WAIT_ROW: in_valid_i=1 accepts column 0 -> ROW, col_cnt=1; in_valid_i=0 -> stay, gaps between rows unlimited.
REQ-018 ROW: each cycle in_valid_i=1 accepts column col_cnt and increments col_cnt.
REQ-019 ROW, in_valid_i=0 before column COLS-1 is accepted -> ERR, err_o=1 from next cycle.
REQ-020 Accepting column COLS-1: col_cnt=0; band_cnt==ROWS-9 -> FLUSH, else band_cnt+1 and -> WAIT_ROW.
REQ-021 COLS=9 edge: column 0 accepted in WAIT_ROW, columns 1..8 in ROW; a single-column row SHALL NOT occur.
REQ-022 count_en_o SHALL be combinational: in_valid_i AND state in {WAIT_ROW, ROW}.
REQ-023 Column c accepted in cycle t with c>=8: win_valid_o=1 in cycle t+2, win_col_o=c-8, win_row_o=band_cnt at t (two-stage pipeline matching datapath input delay plus window stage).
REQ-024 win_valid_o SHALL be 0 in all other cycles; COLS-8 windows per band, ROWS-8 bands per frame.
REQ-025 win_col_o/win_row_o SHALL hold last value when win_valid_o=0.
REQ-026 FLUSH: stay exactly 2 cycles so last window drains; done_o=1 in the second FLUSH cycle, coincident with the final win_valid_o; then -> IDLE.
REQ-027 ERR: win_valid_o forced 0 and pending pipeline valids discarded; start_i=1 -> WAIT_ROW as from IDLE; err_o stays 1 until that restart.
REQ-028 in_valid_i in IDLE, FLUSH or ERR SHALL be ignored (count_en_o=0).

Reset
REQ-029 rst=1 SHALL force IDLE, counters 0, pipeline valids 0, all outputs 0 (win_col_o=0, win_row_o=0) on the next edge, overriding any state including mid-row and FLUSH.
REQ-030 rst SHALL take priority over start_i and in_valid_i in the same cycle.

Verification (COLS=12, ROWS=10 unless stated)
REQ-031 Reset mid-row: 5 columns accepted then rst for 1 cycle -> next cycle busy_o=0, win_valid_o=0, count_en_o=0, no done_o.
REQ-032 Full frame, in_valid_i continuous, 3-cycle gap between rows -> exactly 8 win_valid_o pulses: (col,row) = (0..3,0) then (0..3,1); done_o coincident with (3,1); busy_o=0 the cycle after.
REQ-033 Latency: column 8 of band 0 accepted cycle t -> win_valid_o first high at t+2 with win_col_o=0, win_row_o=0.
REQ-034 Mid-row gap: in_valid_i drops after column 6 -> err_o=1 next cycle, no win_valid_o for that row; start_i then clears err_o and full frame completes normally.
REQ-035 Minimum size COLS=9, ROWS=9: 9 contiguous columns -> single window (0,0), done_o with it.
REQ-036 start_i pulsed during ROW and FLUSH -> no effect: counters and window sequence unchanged vs REQ-032.

Source files
------------

// File: rtl/window_buffer_9x9_ctrl.sv
// Control path for a 9x9 sliding-window buffer: tracks column/band position,
// gates column accepts into the datapath and tags each complete window.
module window_buffer_9x9_ctrl #(
  parameter int COLS = 640,
  parameter int ROWS = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       in_valid_i,
  output logic       count_en_o,
  output logic       win_valid_o,
  output logic [9:0] win_col_o,
  output logic [9:0] win_row_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ROW,
    ROW,
    FLUSH,
    ERR
  } state_t;

  localparam logic [9:0] LAST_COL  = 10'(COLS - 1);
  localparam logic [9:0] LAST_BAND = 10'(ROWS - 9);

  state_t     state_reg;
  logic [9:0] col_cnt_reg;
  logic [9:0] band_cnt_reg;
  logic       flush_cnt_reg;

  // First pipeline stage mirrors the datapath's one-cycle input delay.
  logic       p1_valid_reg;
  logic [9:0] p1_col_reg;
  logic [9:0] p1_row_reg;

  logic       win_ready;

  assign count_en_o = in_valid_i && (state_reg == WAIT_ROW || state_reg == ROW);
  assign busy_o     = (state_reg != IDLE);
  // A window completes once eight earlier columns are already in the buffer.
  assign win_ready  = count_en_o && (col_cnt_reg >= 10'd8);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      col_cnt_reg   <= '0;
      band_cnt_reg  <= '0;
      flush_cnt_reg <= 1'b0;
      p1_valid_reg  <= 1'b0;
      p1_col_reg    <= '0;
      p1_row_reg    <= '0;
      win_valid_o   <= 1'b0;
      win_col_o     <= '0;
      win_row_o     <= '0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      done_o <= 1'b0;

      p1_valid_reg <= win_ready;
      if (win_ready) begin
        p1_col_reg <= col_cnt_reg - 10'd8;
        p1_row_reg <= band_cnt_reg;
      end

      win_valid_o <= p1_valid_reg;
      if (p1_valid_reg) begin
        win_col_o <= p1_col_reg;
        win_row_o <= p1_row_reg;
      end

      case (state_reg)
        IDLE: begin
          if (start_i) begin
            state_reg    <= WAIT_ROW;
            col_cnt_reg  <= '0;
            band_cnt_reg <= '0;
            err_o        <= 1'b0;
          end
        end

        WAIT_ROW: begin
          if (in_valid_i) begin
            state_reg   <= ROW;
            col_cnt_reg <= 10'd1;
          end
        end

        ROW: begin
          if (in_valid_i) begin
            if (col_cnt_reg == LAST_COL) begin
              col_cnt_reg <= '0;
              if (band_cnt_reg == LAST_BAND) begin
                state_reg     <= FLUSH;
                flush_cnt_reg <= 1'b0;
              end else begin
                band_cnt_reg <= band_cnt_reg + 10'd1;
                state_reg    <= WAIT_ROW;
              end
            end else begin
              col_cnt_reg <= col_cnt_reg + 10'd1;
            end
          end else begin
            // Mid-row gap: the buffered columns are no longer contiguous.
            state_reg    <= ERR;
            err_o        <= 1'b1;
            p1_valid_reg <= 1'b0;
            win_valid_o  <= 1'b0;
          end
        end

        FLUSH: begin
          if (!flush_cnt_reg) begin
            flush_cnt_reg <= 1'b1;
            done_o        <= 1'b1;
          end else begin
            flush_cnt_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end

        ERR: begin
          p1_valid_reg <= 1'b0;
          win_valid_o  <= 1'b0;
          if (start_i) begin
            state_reg    <= WAIT_ROW;
            col_cnt_reg  <= '0;
            band_cnt_reg <= '0;
            err_o        <= 1'b0;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_window_buffer_9x9_ctrl.sv
// Bench for window_buffer_9x9_ctrl: cycle table on a 9x9 instance, directed
// frame sequences with a window scoreboard on a 12x10 instance.
module tb_window_buffer_9x9_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // 12x10 instance
  logic       a_rst = 1'b1, a_start = 1'b0, a_iv = 1'b0;
  logic       a_ce, a_wv, a_busy, a_done, a_err;
  logic [9:0] a_col, a_row;

  window_buffer_9x9_ctrl #(.COLS(12), .ROWS(10)) dut_a (
    .clk(clk), .rst(a_rst), .start_i(a_start), .in_valid_i(a_iv),
    .count_en_o(a_ce), .win_valid_o(a_wv), .win_col_o(a_col), .win_row_o(a_row),
    .busy_o(a_busy), .done_o(a_done), .err_o(a_err)
  );

  // 9x9 instance
  logic       b_rst = 1'b1, b_start = 1'b0, b_iv = 1'b0;
  logic       b_ce, b_wv, b_busy, b_done, b_err;
  logic [9:0] b_col, b_row;

  window_buffer_9x9_ctrl #(.COLS(9), .ROWS(9)) dut_b (
    .clk(clk), .rst(b_rst), .start_i(b_start), .in_valid_i(b_iv),
    .count_en_o(b_ce), .win_valid_o(b_wv), .win_col_o(b_col), .win_row_o(b_row),
    .busy_o(b_busy), .done_o(b_done), .err_o(b_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic       r, s, v;
    logic       ce, wv;
    logic [9:0] col, row;
    logic       busy, done, err;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t mk(input int r, s, v, ce, wv, col, row, busy, done, err);
    vec_t t;
    t.r = r[0]; t.s = s[0]; t.v = v[0]; t.ce = ce[0]; t.wv = wv[0];
    t.col = col[9:0]; t.row = row[9:0];
    t.busy = busy[0]; t.done = done[0]; t.err = err[0];
    return t;
  endfunction

  // Observation log for instance A, filled by step_a.
  int         cyc = 0;
  int         obs_col[$], obs_row[$], obs_cyc[$];
  int         done_cnt, done_col, done_row, ce_cnt;
  logic       done_with_wv;
  logic       l_ce, l_wv, l_busy, l_done, l_err;
  logic [9:0] l_col, l_row;

  task automatic step_a(input logic r, input logic s, input logic v);
    @(negedge clk);
    a_rst = r; a_start = s; a_iv = v;
    #1;
    if (a_wv === 1'b1) begin
      obs_col.push_back(int'(a_col));
      obs_row.push_back(int'(a_row));
      obs_cyc.push_back(cyc);
    end
    if (a_done === 1'b1) begin
      done_cnt++;
      done_with_wv = a_wv;
      done_col = int'(a_col);
      done_row = int'(a_row);
    end
    if (a_ce === 1'b1) ce_cnt++;
    l_ce = a_ce; l_wv = a_wv; l_busy = a_busy; l_done = a_done; l_err = a_err;
    l_col = a_col; l_row = a_row;
    cyc++;
  endtask

  task automatic clear_log();
    obs_col.delete(); obs_row.delete(); obs_cyc.delete();
    done_cnt = 0; done_col = -1; done_row = -1; done_with_wv = 1'b0; ce_cnt = 0;
  endtask

  // Full 12x10 frame, 3 idle cycles before each row; noisy adds stray start pulses.
  task automatic run_frame(input bit noisy, input string tag);
    int acc8;
    clear_log();
    acc8 = -1;
    step_a(0, 1, 0);
    for (int b = 0; b < 2; b++) begin
      for (int g = 0; g < 3; g++) begin
        step_a(0, 0, 0);
        if (b == 0 && g == 0) chk({tag, " err cleared by start"}, l_err, 0);
        if (b == 1 && g == 2) begin
          chk({tag, " hold wv"}, l_wv, 0);
          chk({tag, " hold col"}, l_col, 3);
          chk({tag, " hold row"}, l_row, 0);
        end
      end
      for (int c = 0; c < 12; c++) begin
        if (b == 0 && c == 8) acc8 = cyc;
        step_a(0, noisy && (c == 5), 1);
      end
    end
    step_a(0, noisy, 0);
    step_a(0, 0, 0);
    step_a(0, 0, 0);
    chk({tag, " busy after done"}, l_busy, 0);
    chk({tag, " count_en total"}, ce_cnt, 24);
    chk({tag, " window count"}, obs_col.size(), 8);
    if (obs_col.size() == 8) begin
      chk({tag, " first window latency"}, obs_cyc[0], acc8 + 2);
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("%s win%0d col", tag, i), obs_col[i], i % 4);
        chk($sformatf("%s win%0d row", tag, i), obs_row[i], i / 4);
      end
    end
    chk({tag, " done count"}, done_cnt, 1);
    chk({tag, " done with wv"}, done_with_wv, 1);
    chk({tag, " done col"}, done_col, 3);
    chk({tag, " done row"}, done_row, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    //               r s v ce wv col row busy done err
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 1, 1, 0, 0, 0, 1, 0, 0);
    for (int i = 3; i <= 10; i++) tbl[i] = mk(0, 0, 1, 1, 0, 0, 0, 1, 0, 0);
    tbl[11] = mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 1, 0, 0, 1, 1, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[14] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[15] = mk(0, 0, 1, 1, 0, 0, 0, 1, 0, 0);
    tbl[16] = mk(0, 0, 1, 1, 0, 0, 0, 1, 0, 0);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[18] = mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 1);
    tbl[19] = mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 1);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[21] = mk(1, 0, 1, 1, 0, 0, 0, 1, 0, 0);
    tbl[22] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);

    // 9x9 instance: minimum-size frame, gap error, restart, reset.
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      b_rst = tbl[i].r; b_start = tbl[i].s; b_iv = tbl[i].v;
      #1;
      chk($sformatf("v%0d count_en", i), b_ce, tbl[i].ce);
      chk($sformatf("v%0d win_valid", i), b_wv, tbl[i].wv);
      chk($sformatf("v%0d win_col", i), b_col, tbl[i].col);
      chk($sformatf("v%0d win_row", i), b_row, tbl[i].row);
      chk($sformatf("v%0d busy", i), b_busy, tbl[i].busy);
      chk($sformatf("v%0d done", i), b_done, tbl[i].done);
      chk($sformatf("v%0d err", i), b_err, tbl[i].err);
      $display("vec %0d: ce=%0b wv=%0b col=%0d row=%0d busy=%0b done=%0b err=%0b",
               i, b_ce, b_wv, b_col, b_row, b_busy, b_done, b_err);
    end

    // 12x10 instance: reset state.
    step_a(0, 0, 0);
    chk("reset busy", l_busy, 0);
    chk("reset wv", l_wv, 0);
    chk("reset col", l_col, 0);
    chk("reset row", l_row, 0);
    chk("reset done", l_done, 0);
    chk("reset err", l_err, 0);

    // Reset mid-row after 5 accepted columns.
    clear_log();
    step_a(0, 1, 0);
    for (int c = 0; c < 5; c++) step_a(0, 0, 1);
    chk("midrow count_en before rst", ce_cnt, 5);
    step_a(1, 0, 1);
    step_a(0, 0, 1);
    chk("midrow rst busy", l_busy, 0);
    chk("midrow rst wv", l_wv, 0);
    chk("midrow rst count_en", l_ce, 0);
    chk("midrow rst done", done_cnt, 0);
    $display("reset mid-row: busy=%0b ce=%0b", l_busy, l_ce);

    run_frame(0, "clean");
    $display("clean frame: windows=%0d done=%0d", obs_col.size(), done_cnt);

    // Mid-row gap after column 6, then restart.
    clear_log();
    step_a(0, 1, 0);
    step_a(0, 0, 0);
    for (int c = 0; c < 7; c++) step_a(0, 0, 1);
    step_a(0, 0, 0);
    chk("gap err same cycle", l_err, 0);
    step_a(0, 0, 1);
    chk("gap err next cycle", l_err, 1);
    chk("gap count_en in ERR", l_ce, 0);
    chk("gap busy in ERR", l_busy, 1);
    step_a(0, 0, 0);
    chk("gap no windows", obs_col.size(), 0);
    $display("gap error: err=%0b windows=%0d", l_err, obs_col.size());

    run_frame(0, "restart");
    $display("restart frame: windows=%0d done=%0d", obs_col.size(), done_cnt);

    run_frame(1, "noisy");
    $display("noisy-start frame: windows=%0d done=%0d", obs_col.size(), done_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
